// File: rtl/shared_counter_arbiter_pkg.sv
// shared_counter_arbiter_pkg: state encoding, default sizes and onehot helper shared by the counter arbiter.
package shared_counter_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 4;
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction
endpackage

// File: rtl/shared_counter_arbiter_rr_pick.sv
// shared_counter_arbiter_rr_pick: combinational round-robin selector, first set req bit after last, wrapping.
module shared_counter_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    pick,
  output logic             valid
);
  logic [IW-1:0] idx;
  always_comb begin
    pick = '0;
    idx = '0;
    valid = |req;
    // Walk from the farthest candidate inward so the nearest one after last wins.
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % N_REQ);
      if (req[idx]) pick = idx;
    end
  end
endmodule

// File: rtl/shared_counter_arbiter.sv
// shared_counter_arbiter: one up-counter shared round-robin among requesters, each counting 0..len then pulsing done.
module shared_counter_arbiter
  import shared_counter_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*CNT_W-1:0] len,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic [CNT_W-1:0]   q,
  output logic               busy
);
  localparam int IW = $clog2(N_REQ);
  state_t state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d;
  logic [CNT_W-1:0] q_q, q_d, tgt_q, tgt_d;
  logic [IW-1:0] last_q, last_d, pick;
  logic valid, at_tgt, owner_req;
  logic [CNT_W-1:0] len_a [N_REQ];
  for (genvar i = 0; i < N_REQ; i++) begin : g_len
    assign len_a[i] = len[i*CNT_W +: CNT_W];
  end
  shared_counter_arbiter_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_rr_pick (
    .req  (req),
    .last (last_q),
    .pick (pick),
    .valid(valid)
  );
  // last_q doubles as the owner index while a grant is held.
  assign at_tgt = q_q == tgt_q;
  assign owner_req = req[last_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      q_q     <= '0;
      tgt_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      q_q     <= q_d;
      tgt_q   <= tgt_d;
      last_q  <= last_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = valid ? RUN : IDLE;
      RUN:     state_d = at_tgt ? DONE : owner_req ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    grant_d = grant_q;
    done_d  = '0;
    q_d     = q_q;
    tgt_d   = tgt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        grant_d = valid ? N_REQ'(onehot(3'(pick))) : '0;
        last_d  = valid ? pick : last_q;
        tgt_d   = valid ? len_a[pick] : tgt_q;
        q_d     = '0;
      end
      RUN: begin
        // Completion takes precedence over a simultaneous abort.
        done_d  = at_tgt ? grant_q : '0;
        grant_d = (at_tgt || owner_req) ? grant_q : '0;
        q_d     = at_tgt ? q_q : owner_req ? q_q + 1'b1 : '0;
      end
      default: begin
        grant_d = '0;
        q_d     = '0;
      end
    endcase
  end
  always_comb begin
    grant = grant_q;
    done  = done_q;
    q     = q_q;
    busy  = state_q != IDLE;
  end
endmodule

// File: tb/tb_shared_counter_arbiter.sv
// tb_shared_counter_arbiter: directed plus random stimulus against an interval-level reference model with a done scoreboard.
module tb_shared_counter_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  logic clk = 0;
  logic rst = 1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] len = '0;
  logic [N-1:0] grant, done;
  logic [W-1:0] q;
  logic busy;
  typedef struct {int owner; int tgt; int due;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0;
  bit m_busy = 0;
  int m_owner = 0, m_start = 0, m_tgt = 0, m_last = N - 1;

  always #5 clk = ~clk;

  shared_counter_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len  (len),
    .grant(grant),
    .done (done),
    .q    (q),
    .busy (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: an interval owned from m_start; q = elapsed cycles clamped at tgt, done at tgt+1.
  always @(posedge clk) begin
    int e, p;
    cyc++;
    if (rst) begin
      m_busy = 0;
      m_last = N - 1;
      sb.delete();
    end else if (m_busy) begin
      e = cyc - 1 - m_start;
      if (e == m_tgt + 1) m_busy = 0;
      else if (e < m_tgt && !req[m_owner]) begin
        m_busy = 0;
        sb.delete();
      end
    end else begin
      p = -1;
      for (int k = 1; k <= N; k++)
        if (p < 0 && req[(m_last + k) % N]) p = (m_last + k) % N;
      if (p >= 0) begin
        m_busy = 1;
        m_owner = p;
        m_last = p;
        m_start = cyc;
        m_tgt = int'(len[p*W +: W]);
        sb.push_back('{p, m_tgt, cyc + m_tgt + 1});
      end
    end
  end

  always @(negedge clk) begin
    int e;
    exp_t x;
    if (cyc > 0) begin
      e = cyc - m_start;
      chk("busy", busy, m_busy);
      chk("grant", grant, m_busy ? (1 << m_owner) : 0);
      chk("q", q, m_busy ? (e < m_tgt ? e : m_tgt) : 0);
      if (done != 0) begin
        if (sb.size() == 0) chk("done_unexpected", done, 0);
        else begin
          x = sb.pop_front();
          chk("done_owner", done, 1 << x.owner);
          chk("done_q", q, x.tgt);
          chk("done_cycle", cyc, x.due);
        end
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
        chk("done_missing", done, 1 << sb[0].owner);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input int v);
    len[i*W +: W] = W'(v);
  endtask

  task automatic wait_any_done();
    int n = 0;
    while (done == 0 && n < 200) begin tick(); n++; end
    if (done == 0) chk("timeout_done", done, 1);
  endtask

  task automatic wait_q(input int i, input int v);
    int n = 0;
    while (!(grant[i] && int'(q) == v) && n < 200) begin tick(); n++; end
    if (!(grant[i] && int'(q) == v)) chk("timeout_q", q, v);
  endtask

  initial begin
    int r;
    tick(); tick();
    rst = 0;
    set_len(0, 3); req = 4'b0001;
    wait_any_done(); req = '0;
    repeat (3) tick();
    for (int i = 0; i < N; i++) set_len(i, 1);
    req = 4'b1111;
    repeat (4) begin
      wait_any_done();
      req = req & ~done;
      tick();
    end
    repeat (2) tick();
    set_len(2, 0); req = 4'b0100;
    wait_any_done(); req = '0;
    repeat (2) tick();
    set_len(1, 15); req = 4'b0010;
    wait_any_done(); req = '0;
    repeat (2) tick();
    req = 4'b0010;
    wait_q(1, 5); req = '0;
    repeat (3) tick();
    set_len(1, 2); req = 4'b0010;
    wait_q(1, 2); req = '0;
    repeat (3) tick();
    set_len(0, 9); req = 4'b0001;
    wait_q(0, 4); rst = 1;
    tick();
    rst = 0; req = 4'b1010;
    tick();
    chk("rr_after_rst", grant, 4'b0010);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(499) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(2) == 0) begin
            r = $urandom_range(9);
            req[i] = 1'b1;
            set_len(i, r == 0 ? 0 : r == 1 ? 15 : $urandom_range(6));
          end
        end else if (done[i]) begin
          if ($urandom_range(3) != 0) req[i] = 1'b0;
        end else if (grant[i]) begin
          if ($urandom_range(29) == 0) req[i] = 1'b0;
          else if ($urandom_range(4) == 0) set_len(i, $urandom_range(15));
        end
      end
      tick();
    end
    rst = 0; req = '0;
    repeat (40) tick();
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
